// File: rtl/plcp_rx_ctrl.sv
// Receive-side PLCP sequencer for the 802.11b DSSS 1 Mbps path: SFD search with timeout,
// 48-bit header capture and CRC check, then LENGTH-bit payload gating to the MAC.
module plcp_rx_ctrl #(
  parameter int unsigned SFD_TIMEOUT_BITS = 144,
  parameter logic [7:0]  SIGNAL_1M        = 8'h0A,
  parameter logic [15:0] MAX_LENGTH       = 16'd20000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        lock,
  input  logic        data_bit,
  input  logic        data_valid,
  input  logic        sfd_detected,
  output logic [2:0]  rx_state,
  output logic        busy,
  output logic [7:0]  hdr_signal,
  output logic [7:0]  hdr_service,
  output logic [15:0] hdr_length,
  output logic        hdr_valid,
  output logic        hdr_error,
  output logic        sfd_timeout,
  output logic        rx_abort,
  output logic        payload_bit,
  output logic        payload_valid,
  output logic        frame_done
);

  // state   | meaning
  // IDLE    | disabled or unlocked, waiting for enable && lock
  // SEARCH  | counting bits while waiting for the SFD pulse
  // HEADER  | shifting in SIGNAL/SERVICE/LENGTH/CRC
  // PAYLOAD | forwarding LENGTH bits to the MAC
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEARCH  = 3'd1,
    HEADER  = 3'd2,
    PAYLOAD = 3'd3
  } state_t;

  localparam logic [8:0] TIMEOUT_CNT = 9'(SFD_TIMEOUT_BITS);

  state_t      state;
  logic [7:0]  search_cnt;
  logic [5:0]  hdr_cnt;
  logic [15:0] pay_cnt;
  logic [46:0] hdr_sr;

  logic        link_ok;
  logic [8:0]  search_inc;
  logic [47:0] hdr_word;
  logic [15:0] crc_calc;
  logic [15:0] crc_rx;
  logic        crc_fb;
  logic        hdr_ok;

  assign link_ok    = enable & lock;
  assign search_inc = {1'b0, search_cnt} + 9'd1;
  // Complete header as it stands once the current bit (bit 47) is included.
  assign hdr_word   = {data_bit, hdr_sr};
  assign rx_state   = state;
  assign busy       = (state != IDLE);

  always_comb begin
    crc_calc = 16'hFFFF;
    crc_fb   = 1'b0;
    for (int i = 0; i < 32; i++) begin
      crc_fb   = crc_calc[15] ^ hdr_word[i];
      crc_calc = {crc_calc[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
    end
  end

  // CRC field is sent x^15 first, so header bit 32 is crc_rx[15].
  always_comb begin
    crc_rx = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      crc_rx[15-i] = hdr_word[32+i];
    end
  end

  assign hdr_ok = (crc_rx == ~crc_calc) &&
                  (hdr_word[7:0] == SIGNAL_1M) &&
                  (hdr_word[31:16] != 16'd0) &&
                  (hdr_word[31:16] <= MAX_LENGTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      search_cnt    <= '0;
      hdr_cnt       <= '0;
      pay_cnt       <= '0;
      hdr_sr        <= '0;
      hdr_signal    <= '0;
      hdr_service   <= '0;
      hdr_length    <= '0;
      hdr_valid     <= 1'b0;
      hdr_error     <= 1'b0;
      sfd_timeout   <= 1'b0;
      rx_abort      <= 1'b0;
      payload_bit   <= 1'b0;
      payload_valid <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      hdr_valid     <= 1'b0;
      hdr_error     <= 1'b0;
      sfd_timeout   <= 1'b0;
      rx_abort      <= 1'b0;
      payload_valid <= 1'b0;
      frame_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (link_ok) begin
            state      <= SEARCH;
            search_cnt <= '0;
          end
        end
        SEARCH: begin
          if (!link_ok) begin
            state <= IDLE;
          end else if (sfd_detected) begin
            state <= HEADER;
            if (data_valid) begin
              hdr_sr  <= {data_bit, hdr_sr[46:1]};
              hdr_cnt <= 6'd1;
            end else begin
              hdr_cnt <= 6'd0;
            end
          end else if (data_valid) begin
            if (search_inc == TIMEOUT_CNT) begin
              sfd_timeout <= 1'b1;
              state       <= IDLE;
            end
            if (search_cnt != 8'hFF) search_cnt <= search_inc[7:0];
          end
        end
        HEADER: begin
          if (!link_ok) begin
            rx_abort <= 1'b1;
            state    <= IDLE;
          end else if (data_valid) begin
            hdr_sr <= {data_bit, hdr_sr[46:1]};
            if (hdr_cnt != 6'h3F) hdr_cnt <= hdr_cnt + 6'd1;
            if (hdr_cnt == 6'd47) begin
              hdr_signal  <= hdr_word[7:0];
              hdr_service <= hdr_word[15:8];
              hdr_length  <= hdr_word[31:16];
              if (hdr_ok) begin
                hdr_valid <= 1'b1;
                state     <= PAYLOAD;
                pay_cnt   <= '0;
              end else begin
                hdr_error <= 1'b1;
                state     <= IDLE;
              end
            end
          end
        end
        PAYLOAD: begin
          if (!link_ok) begin
            rx_abort <= 1'b1;
            state    <= IDLE;
          end else if (pay_cnt == hdr_length) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end else if (data_valid) begin
            payload_valid <= 1'b1;
            payload_bit   <= data_bit;
            if (pay_cnt != 16'hFFFF) pay_cnt <= pay_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plcp_rx_ctrl.sv
// Self-checking bench for plcp_rx_ctrl: directed frames plus randomized frames compared
// cycle by cycle against a transaction-level reference model.
module tb_plcp_rx_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        lock = 1'b0;
  logic        data_bit = 1'b0;
  logic        data_valid = 1'b0;
  logic        sfd_detected = 1'b0;
  logic [2:0]  rx_state;
  logic        busy;
  logic [7:0]  hdr_signal;
  logic [7:0]  hdr_service;
  logic [15:0] hdr_length;
  logic        hdr_valid;
  logic        hdr_error;
  logic        sfd_timeout;
  logic        rx_abort;
  logic        payload_bit;
  logic        payload_valid;
  logic        frame_done;

  always #5 clk = ~clk;

  plcp_rx_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .lock(lock),
    .data_bit(data_bit), .data_valid(data_valid), .sfd_detected(sfd_detected),
    .rx_state(rx_state), .busy(busy),
    .hdr_signal(hdr_signal), .hdr_service(hdr_service), .hdr_length(hdr_length),
    .hdr_valid(hdr_valid), .hdr_error(hdr_error), .sfd_timeout(sfd_timeout),
    .rx_abort(rx_abort), .payload_bit(payload_bit), .payload_valid(payload_valid),
    .frame_done(frame_done)
  );

  int checks = 0;
  int failures = 0;
  bit cmp_on = 0;

  // CRC by long division: a 16'hFFFF preset is equivalent to inverting the first
  // 16 message bits; the transmitted CRC is the complemented remainder.
  function automatic logic [15:0] crc_ref(input logic [31:0] b);
    logic [47:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) m[47-i] = b[i] ^ (i < 16);
    for (int i = 47; i >= 16; i--) if (m[i]) m[i-:17] = m[i-:17] ^ 17'h11021;
    return ~m[15:0];
  endfunction

  // Reference model: phase 0 idle, 1 search, 2 header, 3 payload.
  int          m_phase = 0;
  int          m_scnt = 0;
  int          m_fwd = 0;
  bit          m_hq[$];
  logic [2:0]  e_state = 0;
  logic [7:0]  e_sig = 0, e_srv = 0;
  logic [15:0] e_len = 0;
  logic        e_hv = 0, e_he = 0, e_to = 0, e_ab = 0, e_pv = 0, e_pb = 0, e_fd = 0;
  logic [31:0] m_hb;
  logic [15:0] m_rc;
  bit          m_lost;

  always @(posedge clk) begin
    e_hv = 0; e_he = 0; e_to = 0; e_ab = 0; e_pv = 0; e_fd = 0;
    if (reset) begin
      m_phase = 0; e_sig = 0; e_srv = 0; e_len = 0; e_pb = 0;
      m_hq.delete();
    end else begin
      m_lost = !(enable && lock);
      case (m_phase)
        0: if (!m_lost) begin m_phase = 1; m_scnt = 0; end
        1: begin
          if (m_lost) m_phase = 0;
          else if (sfd_detected) begin
            m_phase = 2;
            m_hq.delete();
            if (data_valid) m_hq.push_back(data_bit);
          end else if (data_valid) begin
            m_scnt++;
            if (m_scnt == 144) begin e_to = 1; m_phase = 0; end
          end
        end
        2: begin
          if (m_lost) begin e_ab = 1; m_phase = 0; end
          else if (data_valid) begin
            m_hq.push_back(data_bit);
            if (m_hq.size() == 48) begin
              for (int i = 0; i < 32; i++) m_hb[i] = m_hq[i];
              for (int i = 0; i < 16; i++) m_rc[15-i] = m_hq[32+i];
              e_sig = m_hb[7:0]; e_srv = m_hb[15:8]; e_len = m_hb[31:16];
              if (m_rc == crc_ref(m_hb) && e_sig == 8'h0A && e_len >= 1 && e_len <= 20000) begin
                e_hv = 1; m_phase = 3; m_fwd = 0;
              end else begin
                e_he = 1; m_phase = 0;
              end
            end
          end
        end
        default: begin
          if (m_lost) begin e_ab = 1; m_phase = 0; end
          else if (m_fwd == int'(e_len)) begin e_fd = 1; m_phase = 0; end
          else if (data_valid) begin e_pv = 1; e_pb = data_bit; m_fwd++; end
        end
      endcase
    end
    e_state = 3'(m_phase);
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      checks++;
      if ({rx_state, busy, hdr_signal, hdr_service, hdr_length, hdr_valid, hdr_error,
           sfd_timeout, rx_abort, payload_bit, payload_valid, frame_done} !==
          {e_state, (e_state != 0), e_sig, e_srv, e_len, e_hv, e_he,
           e_to, e_ab, e_pb, e_pv, e_fd}) begin
        failures++;
        $display("FAIL cycle_outputs t=%0t actual st=%0d busy=%b sig=%h srv=%h len=%0d hv=%b he=%b to=%b ab=%b pb=%b pv=%b fd=%b required st=%0d busy=%b sig=%h srv=%h len=%0d hv=%b he=%b to=%b ab=%b pb=%b pv=%b fd=%b",
                 $time, rx_state, busy, hdr_signal, hdr_service, hdr_length, hdr_valid, hdr_error,
                 sfd_timeout, rx_abort, payload_bit, payload_valid, frame_done,
                 e_state, (e_state != 0), e_sig, e_srv, e_len, e_hv, e_he, e_to, e_ab, e_pb, e_pv, e_fd);
      end
    end
  end

  // DUT pulse tallies for the hand-computed scenario expectations.
  int hv_cnt = 0, he_cnt = 0, to_cnt = 0, ab_cnt = 0, pv_cnt = 0, fd_cnt = 0;
  always @(negedge clk) begin
    hv_cnt += int'(hdr_valid);
    he_cnt += int'(hdr_error);
    to_cnt += int'(sfd_timeout);
    ab_cnt += int'(rx_abort);
    pv_cnt += int'(payload_valid);
    fd_cnt += int'(frame_done);
  end

  task automatic clr_counts();
    @(negedge clk);
    hv_cnt = 0; he_cnt = 0; to_cnt = 0; ab_cnt = 0; pv_cnt = 0; fd_cnt = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input logic sfd);
    data_bit = b; data_valid = 1'b1; sfd_detected = sfd;
    @(negedge clk);
    data_valid = 1'b0; sfd_detected = 1'b0; data_bit = 1'($urandom);
    repeat ($urandom_range(1, 2)) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] sig, input logic [7:0] srv, input logic [15:0] len,
                           input int crc_flip, input int npay, input int drop_at,
                           input int rst_at, input bit coincide);
    logic [31:0] hb;
    logic [15:0] crc;
    logic [15:0] sfd_word;
    logic        bits[48];
    int          first;
    enable = 1'b1; lock = 1'b0;
    repeat (8) drive_bit(1'b1, 1'b0);
    lock = 1'b1;
    repeat (120) drive_bit(1'b1, 1'b0);
    sfd_word = 16'hF3A0;
    for (int i = 0; i < 16; i++) drive_bit(sfd_word[i], 1'b0);
    hb = {len, srv, sig};
    crc = crc_ref(hb);
    if (crc_flip >= 0) crc[crc_flip] = ~crc[crc_flip];
    for (int i = 0; i < 32; i++) bits[i] = hb[i];
    for (int i = 0; i < 16; i++) bits[32+i] = crc[15-i];
    first = 0;
    if (coincide) begin
      drive_bit(bits[0], 1'b1);
      first = 1;
    end else begin
      sfd_detected = 1'b1;
      @(negedge clk);
      sfd_detected = 1'b0;
    end
    for (int i = first; i < 48; i++) drive_bit(bits[i], 1'b0);
    for (int p = 0; p < npay; p++) begin
      if (p == drop_at) begin
        lock = 1'b0;
        repeat (3) @(negedge clk);
        lock = 1'b1;
      end
      if (p == rst_at) begin
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_payload_state", int'(rx_state), 0);
        chk("reset_mid_payload_pv", int'(payload_valid), 0);
        chk("reset_mid_payload_len", int'(hdr_length), 0);
        reset = 1'b0;
      end
      drive_bit(1'($urandom), 1'b0);
    end
    repeat (4) @(negedge clk);
    lock = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int  k_to;
    bit  vh;
    logic [7:0]  sig;
    logic [15:0] len;
    int  np, dr, cf;
    reset = 1'b1;
    @(negedge clk);
    cmp_on = 1;
    @(negedge clk);
    chk("reset_state", int'(rx_state), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_hdr_length", int'(hdr_length), 0);
    reset = 1'b0;
    @(negedge clk);

    clr_counts();
    run_frame(8'h0A, 8'h00, 16'd16, -1, 16, -1, -1, 0);
    chk("good_hdr_valid", hv_cnt, 1);
    chk("good_hdr_length", int'(hdr_length), 16);
    chk("good_payload_count", pv_cnt, 16);
    chk("good_frame_done", fd_cnt, 1);

    clr_counts();
    run_frame(8'h0A, 8'h00, 16'd16, 5, 16, -1, -1, 0);
    chk("crcbad_hdr_error", he_cnt, 1);
    chk("crcbad_payload_count", pv_cnt, 0);
    chk("crcbad_state", int'(rx_state), 0);

    clr_counts();
    run_frame(8'h14, 8'h00, 16'd16, -1, 16, -1, -1, 0);
    chk("signal14_hdr_error", he_cnt, 1);
    chk("signal14_hdr_signal", int'(hdr_signal), 8'h14);

    clr_counts();
    run_frame(8'h0A, 8'h00, 16'd0, -1, 4, -1, -1, 0);
    chk("len0_hdr_error", he_cnt, 1);
    chk("len0_hdr_valid", hv_cnt, 0);

    clr_counts();
    run_frame(8'h0A, 8'h5C, 16'd20001, -1, 4, -1, -1, 0);
    chk("len20001_hdr_error", he_cnt, 1);

    clr_counts();
    enable = 1'b1; lock = 1'b1;
    repeat (2) @(negedge clk);
    k_to = 0;
    for (int i = 1; i <= 150; i++) begin
      drive_bit(1'b1, 1'b0);
      if (to_cnt == 1 && k_to == 0) k_to = i;
    end
    chk("timeout_bit_index", k_to, 144);
    chk("timeout_count", to_cnt, 1);
    chk("timeout_research_state", int'(rx_state), 1);
    lock = 1'b0;
    repeat (3) @(negedge clk);

    clr_counts();
    run_frame(8'h0A, 8'h00, 16'd16, -1, 16, 5, -1, 0);
    chk("drop_abort", ab_cnt, 1);
    chk("drop_payload_count", pv_cnt, 5);
    chk("drop_frame_done", fd_cnt, 0);

    clr_counts();
    run_frame(8'h0A, 8'h00, 16'd12, -1, 12, -1, -1, 1);
    chk("coincide_hdr_valid", hv_cnt, 1);
    chk("coincide_hdr_signal", int'(hdr_signal), 8'h0A);
    chk("coincide_payload_count", pv_cnt, 12);

    clr_counts();
    run_frame(8'h0A, 8'h33, 16'd16, -1, 16, -1, 8, 0);
    chk("reset_frame_done", fd_cnt, 0);
    chk("reset_payload_count", pv_cnt, 8);

    for (int f = 0; f < 24; f++) begin
      vh  = ($urandom_range(0, 3) != 0);
      sig = vh ? 8'h0A : 8'($urandom);
      len = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
      cf  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : -1;
      np  = int'(len) + int'($urandom_range(0, 2));
      dr  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, np)) : -1;
      run_frame(sig, 8'($urandom), len, cf, np, dr, -1, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
